or_seq_monitor: RTL and testbench
=================================

# or_seq_monitor

Synthesizable hardware monitor that consumes the `start`, `a`, `b` and `stop` control strobes of the sequence-composition stage. It scores every rising edge of `start` against the rule "rose(start) |=> (##1 a) or (b ##2 stop)". It reports per-attempt pass and fail pulses, which alternative satisfied the rule, and saturating pass/fail counters. It sits directly downstream of the stimulus/control stage and gives silicon or FPGA builds the same check that simulation gets from the assertion.

## Interface
- `CNT_W`, default 8: width of the pass and fail counters.
- `clk` input 1: single clock; all sampling is on posedge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: when 0, no new attempts are started; attempts already in flight still complete.
- `start` input 1: antecedent strobe; an attempt begins on its rising edge.
- `a` input 1: alternative s1 term.
- `b` input 1: first term of alternative s2.
- `stop` input 1: last term of alternative s2.
- `clr` input 1: synchronous clear of counters and `fail_seen`; does not affect attempts in flight.
- `pass` output 1: one-cycle pulse when an attempt passes.
- `pass_s1` output 1: qualifies `pass`; the attempt passed via s1.
- `pass_s2` output 1: qualifies `pass`; the attempt passed via s2 only.
- `fail` output 1: one-cycle pulse when an attempt fails.
- `fail_seen` output 1: sticky; set on any `fail`.
- `busy` output 1: at least one attempt is in flight.
- `pass_cnt` output CNT_W: saturating count of passes.
- `fail_cnt` output CNT_W: saturating count of fails.

## Operation
- Trigger condition at edge E0: `start`=1 and registered `start_q`=0 and `en`=1.
- `start_q` resets to 0, so `start`=1 at the first edge after reset counts as a rise.
- `start_q` updates every edge, regardless of `en`.
- Attempt checks, relative to E0:
  - E1: sample `b` into the attempt.
  - E2: sample `a`.
  - E3: sample `stop`, only if still pending.
- Decision rules:
  - E2, `a`=1: pass via s1. This holds even if `b` was 1; s1 takes priority because it completes first.
  - E2, `a`=0 and captured `b`=0: fail.
  - E2, `a`=0 and captured `b`=1: the attempt stays pending.
  - E3, `stop`=1: pass via s2.
  - E3, `stop`=0: fail.
- Implementation: a 3-deep tracking pipeline (stage valid bits plus captured `b`). No shared FSM; each attempt is scored independently.
- Concurrency:
  - A rise needs `start` low for at least one cycle, so triggers are at least 2 edges apart.
  - At most 2 attempts are in flight at once.
  - At most one decision occurs per edge; no collision arbitration is needed.
- Counters:
  - `pass_cnt` and `fail_cnt` each increment by 1 on their respective decision and saturate at 2^CNT_W−1.
  - `clr` zeroes both counters and `fail_seen`.
  - If `clr` and a decision occur on the same edge, the clear wins and the decision is not counted. The pulse outputs still fire.
- `busy` = OR of the pipeline valid bits, including the attempt just triggered.

## Timing
- Reset values: `pass`, `pass_s1`, `pass_s2`, `fail`, `fail_seen` and `busy` are 0; both counters are 0; all pipeline valids are 0.
- Reset is asynchronous; assertion mid-attempt discards every in-flight attempt without a pulse.
- All outputs are registered. A decision at edge En drives the pulses high from En until En+1.
- The counters and `fail_seen` show the updated value from En.
- Latency from trigger edge:
  - Pass via s1: 2 edges.
  - Fail with `b`=0: 2 edges.
  - Pass via s2 or fail on `stop`: 3 edges.
- `busy` rises at E0 and falls at the decision edge, unless another attempt remains in flight.
- `start` held high for N cycles produces exactly one attempt.
- `en` deasserted on the rise edge suppresses that attempt permanently. No late trigger is generated when `en` returns.

## Test plan
- Scoring sequence for scenarios 1–4 (after reset, `start` 0→1 at E0):
  - Scenario 1: `a`=1 at E2. Expect `pass`=`pass_s1`=1 during E2–E3, `pass_cnt`=1, `busy` 0 after E2.
  - Scenario 2: `b`=1 at E1, `a`=0 at E2, `stop`=1 at E3. Expect no pulse at E2, then `pass`=`pass_s2`=1 at E3 and `pass_cnt`=1.
  - Scenario 3: `b`=0 at E1, `a`=0 at E2. Expect `fail`=1 at E2, `fail_cnt`=1, `fail_seen`=1; `stop` at E3 is ignored.
  - Scenario 4: `b`=1 at E1, `a`=0 at E2, `stop`=0 at E3. Expect `fail` at E3.
- Scenario 5, overlap and hold:
  - `start` pattern 1,0,1,0 from E0 gives triggers at E0 and E2.
  - Attempt E0 uses s2 and passes at E3; attempt E2 uses s1 and passes at E4.
  - Expect `pass_cnt`=2 and `busy` continuously high E0–E4.
  - Then hold `start`=1 for 6 cycles: exactly one attempt is scored.
- Scenario 6, corner cases with CNT_W=2:
  - Drive 5 failing attempts: `fail_cnt` saturates at 3.
  - Pulse `clr` on a fail edge: `fail_cnt`=0, `fail_seen`=0, `fail` pulse still seen.
  - Assert `rst_n`=0 at E1 of a pending attempt: no pulse ever; all outputs 0.

Source files
------------

// File: rtl/or_seq_monitor_if.sv
// Control-strobe and result bundle for the sequence-composition monitor.
// master drives the strobes, slave (the monitor) returns the scoring results.
interface or_seq_monitor_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             start;
  logic             a;
  logic             b;
  logic             stop;
  logic             clr;
  logic             pass;
  logic             pass_s1;
  logic             pass_s2;
  logic             fail;
  logic             fail_seen;
  logic             busy;
  logic [CNT_W-1:0] pass_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output en, start, a, b, stop, clr,
    input  pass, pass_s1, pass_s2, fail, fail_seen, busy, pass_cnt, fail_cnt
  );

  modport slave (
    input  en, start, a, b, stop, clr,
    output pass, pass_s1, pass_s2, fail, fail_seen, busy, pass_cnt, fail_cnt
  );
endinterface

// File: rtl/or_seq_monitor.sv
// Scores each rise of start against "rose(start) |=> (##1 a) or (b ##2 stop)"
// with a 3-stage tracking pipeline; every attempt is judged independently.
module or_seq_monitor #(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  or_seq_monitor_if.slave       mon
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             start_q;
  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  logic             b2_q, b2_d;
  logic             v3_q, v3_d;
  logic             pass_q, pass_d;
  logic             pass_s1_q, pass_s1_d;
  logic             pass_s2_q, pass_s2_d;
  logic             fail_q, fail_d;
  logic             fail_seen_q, fail_seen_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             trig;

  always_comb begin
    trig        = mon.start & ~start_q & mon.en;
    v1_d        = trig;
    v2_d        = v1_q;
    b2_d        = v1_q & mon.b;
    v3_d        = 1'b0;
    pass_s1_d   = 1'b0;
    pass_s2_d   = 1'b0;
    fail_d      = 1'b0;

    // s1 resolves one edge before s2 can, so a=1 wins even when b was captured
    if (v2_q) begin
      if (mon.a) begin
        pass_s1_d = 1'b1;
      end else if (!b2_q) begin
        fail_d = 1'b1;
      end else begin
        v3_d = 1'b1;
      end
    end

    if (v3_q) begin
      if (mon.stop) begin
        pass_s2_d = 1'b1;
      end else begin
        fail_d = 1'b1;
      end
    end

    pass_d = pass_s1_d | pass_s2_d;
    busy_d = v1_d | v2_d | v3_d;

    pass_cnt_d  = pass_cnt_q;
    fail_cnt_d  = fail_cnt_q;
    fail_seen_d = fail_seen_q | fail_d;
    if (pass_d && pass_cnt_q != CNT_MAX) begin
      pass_cnt_d = pass_cnt_q + 1'b1;
    end
    if (fail_d && fail_cnt_q != CNT_MAX) begin
      fail_cnt_d = fail_cnt_q + 1'b1;
    end
    // clear overrides a same-edge decision for the counters only
    if (mon.clr) begin
      pass_cnt_d  = '0;
      fail_cnt_d  = '0;
      fail_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      b2_q        <= 1'b0;
      v3_q        <= 1'b0;
      pass_q      <= 1'b0;
      pass_s1_q   <= 1'b0;
      pass_s2_q   <= 1'b0;
      fail_q      <= 1'b0;
      fail_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      pass_cnt_q  <= '0;
      fail_cnt_q  <= '0;
    end else begin
      start_q     <= mon.start;
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      b2_q        <= b2_d;
      v3_q        <= v3_d;
      pass_q      <= pass_d;
      pass_s1_q   <= pass_s1_d;
      pass_s2_q   <= pass_s2_d;
      fail_q      <= fail_d;
      fail_seen_q <= fail_seen_d;
      busy_q      <= busy_d;
      pass_cnt_q  <= pass_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
    end
  end

  assign mon.pass      = pass_q;
  assign mon.pass_s1   = pass_s1_q;
  assign mon.pass_s2   = pass_s2_q;
  assign mon.fail      = fail_q;
  assign mon.fail_seen = fail_seen_q;
  assign mon.busy      = busy_q;
  assign mon.pass_cnt  = pass_cnt_q;
  assign mon.fail_cnt  = fail_cnt_q;
endmodule

// File: tb/tb_or_seq_monitor.sv
// Bench for or_seq_monitor: directed table, hand-written corner sequences and
// random stimulus against a history-based rule model; CNT_W=8 and CNT_W=2 copies.
module tb_or_seq_monitor;
  localparam int NH = 4096;

  logic clk;
  logic rst_n;

  or_seq_monitor_if #(.CNT_W(8)) m8 ();
  or_seq_monitor_if #(.CNT_W(2)) m2 ();

  assign m2.en    = m8.en;
  assign m2.start = m8.start;
  assign m2.a     = m8.a;
  assign m2.b     = m8.b;
  assign m2.stop  = m8.stop;
  assign m2.clr   = m8.clr;

  or_seq_monitor #(.CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .mon(m8));
  or_seq_monitor #(.CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .mon(m2));

  always #5 clk = ~clk;

  typedef struct {
    bit       st, a, b, sp, en, clr;
    bit [3:0] pulses;   // {pass, pass_s1, pass_s2, fail}
    bit       busy;
  } vec_t;

  vec_t vecs[$];

  int tests = 0;
  int fails = 0;

  // Input history since the last reset, indexed by edge number
  bit st_h[NH], a_h[NH], b_h[NH], sp_h[NH], en_h[NH], clr_h[NH];
  int cyc;
  int mp8, mf8, mp2, mf2;
  bit mfs;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic bit trig(input int n);
    if (n < 0) return 1'b0;
    return st_h[n] && (n == 0 || !st_h[n-1]) && en_h[n];
  endfunction

  task automatic model_reset();
    cyc = 0;
    mp8 = 0; mf8 = 0; mp2 = 0; mf2 = 0;
    mfs = 1'b0;
  endtask

  task automatic add(input bit st, a, b, sp, en, clr, input bit [3:0] pulses, input bit busy);
    vec_t v;
    v.st = st; v.a = a; v.b = b; v.sp = sp; v.en = en; v.clr = clr;
    v.pulses = pulses; v.busy = busy;
    vecs.push_back(v);
  endtask

  // One clock edge: drive, sample at the edge, compare 1 time unit later.
  task automatic step(input bit st, a, b, sp, en, clr);
    bit s1, s2, f1, f2, pend, busy_e;
    m8.start = st; m8.a = a; m8.b = b; m8.stop = sp; m8.en = en; m8.clr = clr;
    @(posedge clk);
    st_h[cyc] = st; a_h[cyc] = a; b_h[cyc] = b;
    sp_h[cyc] = sp; en_h[cyc] = en; clr_h[cyc] = clr;
    s1   = trig(cyc-2) && a_h[cyc];
    f1   = trig(cyc-2) && !a_h[cyc] && !b_h[cyc-1];
    pend = trig(cyc-2) && !a_h[cyc] && b_h[cyc-1];
    s2   = trig(cyc-3) && !a_h[cyc-1] && b_h[cyc-2] && sp_h[cyc];
    f2   = trig(cyc-3) && !a_h[cyc-1] && b_h[cyc-2] && !sp_h[cyc];
    busy_e = trig(cyc) || trig(cyc-1) || pend;
    if (clr) begin
      mp8 = 0; mf8 = 0; mp2 = 0; mf2 = 0; mfs = 1'b0;
    end else begin
      if (s1 || s2) begin
        if (mp8 < 255) mp8++;
        if (mp2 < 3) mp2++;
      end
      if (f1 || f2) begin
        if (mf8 < 255) mf8++;
        if (mf2 < 3) mf2++;
        mfs = 1'b1;
      end
    end
    #1;
    chk("pulses8", {m8.pass, m8.pass_s1, m8.pass_s2, m8.fail}, {s1 || s2, s1, s2, f1 || f2});
    chk("pulses2", {m2.pass, m2.pass_s1, m2.pass_s2, m2.fail}, {s1 || s2, s1, s2, f1 || f2});
    chk("busy", m8.busy, busy_e);
    chk("fail_seen", m8.fail_seen, mfs);
    chk("pass_cnt8", m8.pass_cnt, mp8);
    chk("fail_cnt8", m8.fail_cnt, mf8);
    chk("pass_cnt2", m2.pass_cnt, mp2);
    chk("fail_cnt2", m2.fail_cnt, mf2);
    $display("[TB] edge %0d st=%0b a=%0b b=%0b stop=%0b en=%0b clr=%0b -> pass=%0b s1=%0b s2=%0b fail=%0b busy=%0b pc=%0d fc=%0d",
             cyc, st, a, b, sp, en, clr, m8.pass, m8.pass_s1, m8.pass_s2, m8.fail,
             m8.busy, m8.pass_cnt, m8.fail_cnt);
    cyc++;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, {m8.pass, m8.pass_s1, m8.pass_s2, m8.fail, m8.fail_seen, m8.busy,
             m2.pass, m2.fail, m2.busy}, 0);
    chk({nm, "_cnt"}, {m8.pass_cnt, m8.fail_cnt, m2.pass_cnt, m2.fail_cnt}, 0);
  endtask

  // Reset is released between edges; the model restarts at edge 0.
  task automatic do_reset();
    m8.start = 0; m8.a = 0; m8.b = 0; m8.stop = 0; m8.en = 1; m8.clr = 0;
    rst_n = 0;
    #1;
    chk_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_hold");
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    clk = 0;
    rst_n = 0;
    m8.start = 0; m8.a = 0; m8.b = 0; m8.stop = 0; m8.en = 0; m8.clr = 0;
    model_reset();

    // st a b sp en clr | {pass,s1,s2,fail} busy
    // Scenario 1: pass via s1
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(0,0,0,0,1,0, 4'b0000, 1);
    add(0,1,0,0,1,0, 4'b1100, 0);
    add(0,0,0,0,1,0, 4'b0000, 0);
    // Scenario 2: pass via s2
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(0,0,1,0,1,0, 4'b0000, 1);
    add(0,0,0,0,1,0, 4'b0000, 1);
    add(0,0,0,1,1,0, 4'b1010, 0);
    add(0,0,0,0,1,0, 4'b0000, 0);
    // Scenario 3: fail with b=0, stop ignored
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(0,0,0,0,1,0, 4'b0000, 1);
    add(0,0,0,0,1,0, 4'b0001, 0);
    add(0,0,0,1,1,0, 4'b0000, 0);
    // Scenario 4: fail on stop=0
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(0,0,1,0,1,0, 4'b0000, 1);
    add(0,0,0,0,1,0, 4'b0000, 1);
    add(0,0,0,0,1,0, 4'b0001, 0);
    add(0,0,0,0,1,0, 4'b0000, 0);
    // Scenario 5: overlapping attempts at E0 (s2) and E2 (s1)
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(0,0,1,0,1,0, 4'b0000, 1);
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(0,0,0,1,1,0, 4'b1010, 1);
    add(0,1,0,0,1,0, 4'b1100, 0);
    add(0,0,0,0,1,0, 4'b0000, 0);
    // start held for 6 cycles: one attempt
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(1,0,0,0,1,0, 4'b0000, 1);
    add(1,1,0,0,1,0, 4'b1100, 0);
    add(1,1,0,0,1,0, 4'b0000, 0);
    add(1,1,0,0,1,0, 4'b0000, 0);
    add(1,1,0,0,1,0, 4'b0000, 0);
    add(0,0,0,0,1,0, 4'b0000, 0);
    // rise while en=0 is dropped for good
    add(1,0,0,0,0,0, 4'b0000, 0);
    add(1,0,0,0,1,0, 4'b0000, 0);
    add(1,1,0,0,1,0, 4'b0000, 0);
    add(0,1,0,0,1,0, 4'b0000, 0);

    do_reset();
    foreach (vecs[i]) begin
      step(vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].sp, vecs[i].en, vecs[i].clr);
      chk($sformatf("tbl%0d_pulses", i), {m8.pass, m8.pass_s1, m8.pass_s2, m8.fail}, vecs[i].pulses);
      chk($sformatf("tbl%0d_busy", i), m8.busy, vecs[i].busy);
    end
    chk("tbl_pass_cnt", m8.pass_cnt, 5);
    chk("tbl_fail_cnt", m8.fail_cnt, 2);
    chk("tbl_pass_cnt2_sat", m2.pass_cnt, 3);

    // Scenario 6: saturation, clear on a fail edge, reset mid-attempt
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(1,0,0,0,1,0);
      step(0,0,0,0,1,0);
      step(0,0,0,0,1,0);
      step(0,0,0,0,1,0);
    end
    chk("sat_fail_cnt2", m2.fail_cnt, 3);
    chk("sat_fail_cnt8", m8.fail_cnt, 5);
    chk("sat_fail_seen", m8.fail_seen, 1);

    step(1,0,0,0,1,0);
    step(0,0,0,0,1,0);
    step(0,0,0,0,1,1);
    chk("clr_fail_pulse", m8.fail, 1);
    chk("clr_fail_cnt", m8.fail_cnt, 0);
    chk("clr_fail_cnt2", m2.fail_cnt, 0);
    chk("clr_fail_seen", m8.fail_seen, 0);
    step(0,0,0,0,1,0);

    step(1,0,0,0,1,0);
    step(0,0,1,0,1,0);
    #2;
    rst_n = 0;
    #1;
    chk_all_zero("rst_mid");
    m8.start = 0; m8.a = 0; m8.b = 0; m8.stop = 1; m8.en = 1; m8.clr = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_all_zero("rst_mid_hold");
    end
    rst_n = 1;
    model_reset();
    for (int k = 0; k < 4; k++) step(0,0,0,1,1,0);

    // Random phase with occasional clears and mid-run resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end
      step($urandom_range(0, 9) < 4, $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 19) < 17, $urandom_range(0, 49) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
